// File: rtl/power_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : power_debug_ctrl
// Brief    : Per-domain power sequencers plus a registered, power-gated debug mux.
// Revision : 1.0 - initial release
// ============================================================================
module power_debug_ctrl #(
    parameter int                   DATA_WIDTH  = 8,
    parameter int                   NUM_CH      = 4,
    parameter int                   NUM_DOMAINS = 3,
    parameter int                   WAKE_CYCLES = 4,
    parameter logic [4*NUM_CH-1:0]  CH_DOMAIN   = 16'h21F0,
    parameter int                   SEL_WIDTH   = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_DOMAINS-1:0]       power_req,
    output logic [NUM_DOMAINS-1:0]       pwr_sw_en,
    output logic [NUM_DOMAINS-1:0]       iso_en,
    output logic [NUM_DOMAINS-1:0]       clk_en,
    output logic [NUM_DOMAINS-1:0]       pwr_ack,
    input  logic                         debug_enable,
    input  logic                         debug_freeze,
    input  logic [SEL_WIDTH-1:0]         debug_sel,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    output logic [DATA_WIDTH-1:0]        debug_data_out,
    output logic                         debug_valid
);

    localparam int c_cnt_w = $clog2(WAKE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_wake_last = c_cnt_w'(WAKE_CYCLES - 1);

    localparam logic [2:0] c_st_off     = 3'd0;
    localparam logic [2:0] c_st_wake    = 3'd1;
    localparam logic [2:0] c_st_clk_on  = 3'd2;
    localparam logic [2:0] c_st_on      = 3'd3;
    localparam logic [2:0] c_st_iso     = 3'd4;
    localparam logic [2:0] c_st_clk_off = 3'd5;

    logic [NUM_DOMAINS-1:0] w_dom_on;
    logic [NUM_CH-1:0]      w_ch_pwr;

    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
        logic [2:0]         r_state;
        logic [2:0]         w_next;
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_sw;
        logic               r_iso;
        logic               r_clk;
        logic               r_ack;

        // The request is only looked at in OFF and ON so sequences stay atomic.
        always_comb begin
            w_next = r_state;
            case (r_state)
                c_st_off:     if (power_req[d]) w_next = c_st_wake;
                c_st_wake:    if (r_cnt == c_wake_last) w_next = c_st_clk_on;
                c_st_clk_on:  w_next = c_st_on;
                c_st_on:      if (!power_req[d]) w_next = c_st_iso;
                c_st_iso:     w_next = c_st_clk_off;
                c_st_clk_off: w_next = c_st_off;
                default:      w_next = c_st_off;
            endcase
        end

        // Outputs are flops loaded from the next state, so they track r_state exactly.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= c_st_off;
                r_cnt   <= '0;
                r_sw    <= 1'b0;
                r_iso   <= 1'b1;
                r_clk   <= 1'b0;
                r_ack   <= 1'b0;
            end else begin
                r_state <= w_next;
                r_cnt   <= (r_state == c_st_wake && w_next == c_st_wake) ? r_cnt + 1'b1 : '0;
                r_sw    <= (w_next != c_st_off);
                r_iso   <= (w_next != c_st_on);
                r_clk   <= (w_next == c_st_clk_on) || (w_next == c_st_on) || (w_next == c_st_iso);
                r_ack   <= (w_next == c_st_on);
            end
        end

        assign pwr_sw_en[d] = r_sw;
        assign iso_en[d]    = r_iso;
        assign clk_en[d]    = r_clk;
        assign pwr_ack[d]   = r_ack;
        assign w_dom_on[d]  = r_ack;
    end

    // Domain indices outside the implemented range (including 4'hF) are always-on.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int c_dom = int'(CH_DOMAIN[4*i +: 4]);
        if (c_dom >= NUM_DOMAINS) begin : g_aon
            assign w_ch_pwr[i] = 1'b1;
        end else begin : g_gated
            assign w_ch_pwr[i] = w_dom_on[c_dom];
        end
    end

    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_pwr;

    // An out-of-range select matches no channel and therefore reads as unpowered.
    always_comb begin
        w_sel_data = '0;
        w_sel_pwr  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (debug_sel == SEL_WIDTH'(i)) begin
                w_sel_data = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_pwr  = w_ch_pwr[i];
            end
        end
    end

    logic [DATA_WIDTH-1:0] r_dbg_data;
    logic                  r_dbg_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dbg_data  <= '0;
            r_dbg_valid <= 1'b0;
        end else if (!debug_enable) begin
            r_dbg_data  <= '0;
            r_dbg_valid <= 1'b0;
        end else if (!debug_freeze) begin
            r_dbg_data  <= w_sel_pwr ? w_sel_data : '0;
            r_dbg_valid <= w_sel_pwr;
        end
    end

    assign debug_data_out = r_dbg_data;
    assign debug_valid    = r_dbg_valid;

endmodule
`default_nettype wire

// File: tb/tb_power_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_power_debug_ctrl
// Brief    : Directed self-checking bench for power_debug_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_power_debug_ctrl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  power_req;
    logic [2:0]  pwr_sw_en;
    logic [2:0]  iso_en;
    logic [2:0]  clk_en;
    logic [2:0]  pwr_ack;
    logic        debug_enable;
    logic        debug_freeze;
    logic [1:0]  debug_sel;
    logic [31:0] ch_data;
    logic [7:0]  debug_data_out;
    logic        debug_valid;

    int errors;
    int checks;

    power_debug_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .power_req      (power_req),
        .pwr_sw_en      (pwr_sw_en),
        .iso_en         (iso_en),
        .clk_en         (clk_en),
        .pwr_ack        (pwr_ack),
        .debug_enable   (debug_enable),
        .debug_freeze   (debug_freeze),
        .debug_sel      (debug_sel),
        .ch_data        (ch_data),
        .debug_data_out (debug_data_out),
        .debug_valid    (debug_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Domain-0 power-up profile {sw,iso,clk,ack} for edges 1..6 after the request is seen.
    task automatic test_reset();
        logic [3:0]  up [6];
        logic [11:0] exp_v;
        up = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1110, 4'b1011};
        reset_n = 1'b0; power_req = 3'b001; debug_enable = 1'b0;
        debug_freeze = 1'b0; debug_sel = 2'd0; ch_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pwr_sw_en, iso_en, clk_en, pwr_ack} !== 12'b000_111_000_000) begin
            errors++;
            $display("FAIL reset_pwr: got %b expected %b", {pwr_sw_en, iso_en, clk_en, pwr_ack}, 12'b000_111_000_000);
        end
        checks++;
        if (debug_data_out !== 8'h00 || debug_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_dbg: got %h/%b expected 00/0", debug_data_out, debug_valid);
        end
        reset_n = 1'b1;
        for (int e = 0; e < 6; e++) begin
            step();
            exp_v = {2'b00, up[e][3], 2'b11, up[e][2], 2'b00, up[e][1], 2'b00, up[e][0]};
            checks++;
            if ({pwr_sw_en, iso_en, clk_en, pwr_ack} !== exp_v) begin
                errors++;
                $display("FAIL powerup_edge%0d: got %b expected %b", e + 1, {pwr_sw_en, iso_en, clk_en, pwr_ack}, exp_v);
            end
        end
    endtask

    task automatic test_atomic_down();
        logic [3:0]  seq [9];
        logic [11:0] exp_v;
        seq = '{4'b1110, 4'b1100, 4'b0100, 4'b1100, 4'b1100,
                4'b1100, 4'b1100, 4'b1110, 4'b1011};
        power_req = 3'b000;
        for (int e = 0; e < 9; e++) begin
            step();
            if (e == 0) power_req = 3'b001;
            exp_v = {2'b00, seq[e][3], 2'b11, seq[e][2], 2'b00, seq[e][1], 2'b00, seq[e][0]};
            checks++;
            if ({pwr_sw_en, iso_en, clk_en, pwr_ack} !== exp_v) begin
                errors++;
                $display("FAIL atomic_edge%0d: got %b expected %b", e + 1, {pwr_sw_en, iso_en, clk_en, pwr_ack}, exp_v);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0]  up [6];
        logic [11:0] exp_v;
        up = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1110, 4'b1011};
        power_req = 3'b011;
        step();
        step();
        checks++;
        if (pwr_sw_en !== 3'b011 || pwr_ack !== 3'b001) begin
            errors++;
            $display("FAIL midreset_pre: got sw=%b ack=%b expected sw=011 ack=001", pwr_sw_en, pwr_ack);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pwr_sw_en, iso_en, clk_en, pwr_ack} !== 12'b000_111_000_000) begin
            errors++;
            $display("FAIL midreset_async: got %b expected %b", {pwr_sw_en, iso_en, clk_en, pwr_ack}, 12'b000_111_000_000);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int e = 0; e < 6; e++) begin
            step();
            exp_v = {1'b0, {2{up[e][3]}}, 1'b1, {2{up[e][2]}}, 1'b0, {2{up[e][1]}}, 1'b0, {2{up[e][0]}}};
            checks++;
            if ({pwr_sw_en, iso_en, clk_en, pwr_ack} !== exp_v) begin
                errors++;
                $display("FAIL restart_edge%0d: got %b expected %b", e + 1, {pwr_sw_en, iso_en, clk_en, pwr_ack}, exp_v);
            end
        end
    endtask

    task automatic test_debug_routing();
        logic [7:0] exp_d [4];
        exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        power_req = 3'b111;
        ch_data = 32'hD4C3B2A1;
        for (int n = 0; n < 20 && pwr_ack !== 3'b111; n++) step();
        checks++;
        if (pwr_ack !== 3'b111) begin
            errors++;
            $display("FAIL all_on_timeout: got ack=%b expected 111", pwr_ack);
        end
        debug_enable = 1'b1;
        for (int s = 0; s < 4; s++) begin
            debug_sel = 2'(s);
            step();
            checks++;
            if (debug_data_out !== exp_d[s] || debug_valid !== 1'b1) begin
                errors++;
                $display("FAIL route_sel%0d: got %h/%b expected %h/1", s, debug_data_out, debug_valid, exp_d[s]);
            end
        end
        debug_enable = 1'b0;
        step();
        checks++;
        if (debug_data_out !== 8'h00 || debug_valid !== 1'b0) begin
            errors++;
            $display("FAIL route_disable: got %h/%b expected 00/0", debug_data_out, debug_valid);
        end
    endtask

    task automatic test_freeze();
        debug_enable = 1'b1;
        debug_sel = 2'd2;
        step();
        checks++;
        if (debug_data_out !== 8'hC3 || debug_valid !== 1'b1) begin
            errors++;
            $display("FAIL freeze_setup: got %h/%b expected c3/1", debug_data_out, debug_valid);
        end
        debug_freeze = 1'b1;
        ch_data = 32'h11223344;
        debug_sel = 2'd0;
        for (int n = 0; n < 2; n++) begin
            step();
            checks++;
            if (debug_data_out !== 8'hC3 || debug_valid !== 1'b1) begin
                errors++;
                $display("FAIL freeze_hold%0d: got %h/%b expected c3/1", n, debug_data_out, debug_valid);
            end
        end
        debug_enable = 1'b0;
        step();
        checks++;
        if (debug_data_out !== 8'h00 || debug_valid !== 1'b0) begin
            errors++;
            $display("FAIL freeze_disable: got %h/%b expected 00/0", debug_data_out, debug_valid);
        end
        debug_enable = 1'b1;
        step();
        checks++;
        if (debug_data_out !== 8'h00 || debug_valid !== 1'b0) begin
            errors++;
            $display("FAIL freeze_hold_zero: got %h/%b expected 00/0", debug_data_out, debug_valid);
        end
        debug_freeze = 1'b0;
        ch_data = 32'hD4C3B2A1;
    endtask

    task automatic test_gating();
        debug_enable = 1'b1;
        debug_sel = 2'd2;
        step();
        checks++;
        if (debug_data_out !== 8'hC3 || debug_valid !== 1'b1) begin
            errors++;
            $display("FAIL gate_setup: got %h/%b expected c3/1", debug_data_out, debug_valid);
        end
        power_req = 3'b101;
        step();
        checks++;
        if (debug_data_out !== 8'hC3 || debug_valid !== 1'b1 || pwr_ack !== 3'b101 || iso_en !== 3'b010) begin
            errors++;
            $display("FAIL gate_iso_entry: got %h/%b ack=%b iso=%b expected c3/1 ack=101 iso=010",
                     debug_data_out, debug_valid, pwr_ack, iso_en);
        end
        step();
        checks++;
        if (debug_data_out !== 8'h00 || debug_valid !== 1'b0) begin
            errors++;
            $display("FAIL gate_masked: got %h/%b expected 00/0", debug_data_out, debug_valid);
        end
        debug_sel = 2'd1;
        step();
        checks++;
        if (debug_data_out !== 8'hB2 || debug_valid !== 1'b1) begin
            errors++;
            $display("FAIL gate_always_on: got %h/%b expected b2/1", debug_data_out, debug_valid);
        end
        debug_sel = 2'd3;
        step();
        checks++;
        if (debug_data_out !== 8'hD4 || debug_valid !== 1'b1) begin
            errors++;
            $display("FAIL gate_other_dom: got %h/%b expected d4/1", debug_data_out, debug_valid);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_atomic_down();
        test_mid_reset();
        test_debug_routing();
        test_freeze();
        test_gating();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
